jtag_uart_width_fifo: RTL
=========================

Name: jtag_uart_width_fifo

Overview:
Parametrised Avalon-MM byte-FIFO slave with a JTAG-UART-style interface. It generalises the fixed per-instance write/read width variants (w8_r64, w16_r32, w32r16) into one block. Write width, read width, depth and full-FIFO write policy are all parameters. It runs in loopback: bytes written to the data register are read back through the same bus. Used as the bench target for characterising width-mismatched UART bus encodings.

Parameters:
WR_BYTES, 1, bytes pushed per data write; legal values 1, 2, 4.
RD_BYTES, 4, bytes popped per data read; legal values 1, 2, 4.
DEPTH, 64, FIFO capacity in bytes; power of 2, range 8..32768.
WR_BLOCK, 1, 1 = stall a write on insufficient space; 0 = drop the write and set the overflow flag.

Ports:
clk_clk  in  1  single clock
reset_reset_n  in  1  asynchronous active-low reset
avbus_chipselect  in  1  slave select
avbus_address  in  1  0 = data register, 1 = status register
avbus_read_n  in  1  active-low read strobe
avbus_readdata  out  32  read data
avbus_write_n  in  1  active-low write strobe
avbus_writedata  in  32  write data
avbus_waitrequest  out  1  stall

Behaviour:
- Interface: one clock domain; reset is asynchronous and active-low.
- Reset: state=IDLE, FIFO empty (wr_ptr=rd_ptr=0, count=0), overflow=0, underflow=0, last_cnt=0, readdata=0. Waitrequest=1 while reset is asserted.
- Request decoding:
  - rd_req = chipselect & !read_n.
  - wr_req = chipselect & !write_n.
  - If both are asserted, the read wins and the write is ignored, with no side effects.
- Waitrequest is 1 in every cycle except the cycle that completes a transfer.
- FSM IDLE:
  - rd_req: waitrequest=1. At the clock edge, load readdata, perform any pop, go to RD_DONE.
  - wr_req, address 0, free >= WR_BYTES: waitrequest=0. Push writedata[8*WR_BYTES-1:0] at the edge, byte 0 first (little-endian). Stay in IDLE.
  - wr_req, address 0, free < WR_BYTES, WR_BLOCK=1: waitrequest=1. Stay in IDLE until space frees; no partial push.
  - wr_req, address 0, free < WR_BYTES, WR_BLOCK=0: waitrequest=0. Whole word dropped, overflow<=1.
  - wr_req, address 1: waitrequest=0. writedata[16]=1 clears overflow; writedata[17]=1 clears underflow.
- FSM RD_DONE: waitrequest=0 and readdata is valid. Return to IDLE unconditionally. Read latency is 2 cycles; a back-to-back read re-enters IDLE first.
- Data read (address 0):
  - n = min(count, RD_BYTES) bytes are popped.
  - readdata[8*i+7:8*i] = i-th oldest byte for i<n; all other bits are 0.
  - last_cnt<=n. underflow<=1 if n<RD_BYTES, including the empty case where n=0.
- Status read (address 1), no pop:
  - [15:0] count, zero-extended.
  - [16] overflow. [17] underflow.
  - [18] full (count==DEPTH). [19] empty (count==0).
  - [22:20] last_cnt.
  - [31:23] 0.
- FIFO:
  - Pointers are log2(DEPTH) bits and wrap mod DEPTH. count is log2(DEPTH)+1 bits and never exceeds DEPTH or drops below 0.
  - A push and a pop never occur in the same cycle, because transfers are serialised.
  - Bytes split across the pointer wrap are stored and returned in order.
- Overflow and underflow are sticky and cleared only via status write or reset.
- Reset mid-transfer: FSM returns to IDLE, FIFO is emptied, and the in-flight transfer is discarded.

Test Plan:
- Reset, then status read -> readdata=0x0008_0000 (empty=1, count=0); waitrequest=1 at the first read cycle and 0 at the second.
- WR_BYTES=1, RD_BYTES=4: write 0x11,0x22,0x33,0x44,0x55, then read data -> 0x44332211. Status -> count=1, last_cnt=4. Read again -> 0x00000055, underflow=1, last_cnt=1.
- WR_BYTES=4, RD_BYTES=1, DEPTH=8, WR_BLOCK=1: write 0xA3A2A1A0 and 0xB3B2B1B0 (full=1). Third write 0xC3C2C1C0 holds waitrequest=1 for 20 cycles. One data read returns 0xA0 (count 8->7), and the write stays stalled because free=1. After 3 more reads the write completes. FIFO then drains in order: A0..A3, B0..B3, C0..C3.
- WR_BLOCK=0, DEPTH=8, WR_BYTES=4: three writes -> third dropped, overflow=1, count=8. Status write 0x0001_0000 -> overflow=0, count unchanged.
- Wrap: DEPTH=8, WR_BYTES=2, RD_BYTES=2: 40 write/read pairs with an incrementing pattern -> every read equals the matching write, and count returns to 0.
- Assert reset_reset_n=0 mid-read in the RD_DONE cycle, with 6 bytes queued -> waitrequest=1 immediately. After release, status shows empty=1, count=0, flags 0.

Source files
------------

// File: rtl/jtag_uart_width_fifo.sv
// Avalon-MM loopback byte FIFO with configurable write/read word widths.
// A data write pushes WR_BYTES bytes; a data read pops up to RD_BYTES bytes, oldest byte in the low lane.
module jtag_uart_width_fifo #(
    parameter int WR_BYTES = 1,
    parameter int RD_BYTES = 4,
    parameter int DEPTH    = 64,
    parameter int WR_BLOCK = 1
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        avbus_chipselect,
    input  logic        avbus_address,
    input  logic        avbus_read_n,
    output logic [31:0] avbus_readdata,
    input  logic        avbus_write_n,
    input  logic [31:0] avbus_writedata,
    output logic        avbus_waitrequest
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] WRB_C   = CW'(WR_BYTES);
    localparam logic [CW-1:0] RDB_C   = CW'(RD_BYTES);
    localparam logic          DROP_MODE = (WR_BLOCK == 32'sd0);

    typedef enum logic [0:0] {IDLE = 1'b0, RD_DONE = 1'b1} state_t;

    state_t          state_r, state_nxt_s;
    logic [7:0]      mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]   count_r, free_s;
    logic            overflow_r, underflow_r;
    logic [2:0]      last_cnt_r, pop_n_s;
    logic [31:0]     readdata_r, rd_word_s;
    logic [15:0]     count16_s;
    logic            rd_req_s, wr_req_s;
    logic            waitrequest_s, push_s, drop_s, rd_load_s, st_wr_s;
    logic            unused_s;

    // Number of bytes a data read would remove right now.
    function automatic logic [2:0] pop_bytes(input logic [CW-1:0] cnt);
        if (cnt < RDB_C) begin
            return 3'(cnt);
        end else begin
            return 3'(RD_BYTES);
        end
    endfunction

    assign rd_req_s  = avbus_chipselect & ~avbus_read_n;
    assign wr_req_s  = avbus_chipselect & ~avbus_write_n;
    assign free_s    = DEPTH_C - count_r;
    assign pop_n_s   = pop_bytes(count_r);
    assign count16_s = 16'(count_r);
    assign unused_s  = ^avbus_writedata;

    // State register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: a read takes one stall cycle then completes in RD_DONE.
    always_comb begin
        state_nxt_s = IDLE;
        case (state_r)
            IDLE:    state_nxt_s = rd_req_s ? RD_DONE : IDLE;
            RD_DONE: state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output/strobe decode; read beats write when both strobes are active.
    always_comb begin
        waitrequest_s = 1'b1;
        push_s        = 1'b0;
        drop_s        = 1'b0;
        rd_load_s     = 1'b0;
        st_wr_s       = 1'b0;
        if (!reset_reset_n) begin
            waitrequest_s = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (rd_req_s) begin
                        rd_load_s = 1'b1;
                    end else if (wr_req_s) begin
                        if (avbus_address) begin
                            st_wr_s       = 1'b1;
                            waitrequest_s = 1'b0;
                        end else if (free_s >= WRB_C) begin
                            push_s        = 1'b1;
                            waitrequest_s = 1'b0;
                        end else if (DROP_MODE) begin
                            drop_s        = 1'b1;
                            waitrequest_s = 1'b0;
                        end else begin
                            waitrequest_s = 1'b1;
                        end
                    end else begin
                        waitrequest_s = 1'b1;
                    end
                end
                RD_DONE: waitrequest_s = 1'b0;
                default: waitrequest_s = 1'b1;
            endcase
        end
    end

    // Read word: status snapshot, or the oldest bytes with unused lanes zeroed.
    always_comb begin
        rd_word_s = 32'd0;
        if (avbus_address) begin
            rd_word_s = {9'd0, last_cnt_r, (count_r == {CW{1'b0}}), (count_r == DEPTH_C),
                         underflow_r, overflow_r, count16_s};
        end else begin
            for (int i = 0; i < RD_BYTES; i++) begin
                if (3'(i) < pop_n_s) begin
                    rd_word_s[8*i +: 8] = mem_r[rd_ptr_r + AW'(i)];
                end else begin
                    rd_word_s[8*i +: 8] = 8'd0;
                end
            end
        end
    end

    // Byte storage; pointer arithmetic wraps naturally at DEPTH.
    always_ff @(posedge clk_clk) begin
        if (push_s) begin
            for (int i = 0; i < WR_BYTES; i++) begin
                mem_r[wr_ptr_r + AW'(i)] <= avbus_writedata[8*i +: 8];
            end
        end
    end

    // Pointers, occupancy, sticky flags and the registered read data.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            count_r     <= {CW{1'b0}};
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
            last_cnt_r  <= 3'd0;
            readdata_r  <= 32'd0;
        end else if (rd_load_s) begin
            readdata_r <= rd_word_s;
            if (!avbus_address) begin
                rd_ptr_r   <= rd_ptr_r + AW'(pop_n_s);
                count_r    <= count_r - CW'(pop_n_s);
                last_cnt_r <= pop_n_s;
                if (pop_n_s != 3'(RD_BYTES)) begin
                    underflow_r <= 1'b1;
                end
            end
        end else if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(WR_BYTES);
            count_r  <= count_r + WRB_C;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (st_wr_s) begin
            if (avbus_writedata[16]) begin
                overflow_r <= 1'b0;
            end
            if (avbus_writedata[17]) begin
                underflow_r <= 1'b0;
            end
        end
    end

    assign avbus_readdata    = readdata_r;
    assign avbus_waitrequest = waitrequest_s;

endmodule
